// File: rtl/game_flow_controller.sv
// Top-level game sequencer: start screen, frame draw/stall/erase/update loop and game over,
// with a req/done drawer handshake, tick-paced frames, button edge detection, lives and frame counts.
module game_flow_controller #(
    parameter int NUM_BTNS    = 4,
    parameter int START_BTN   = 0,
    parameter int FRAME_TICKS = 1,
    parameter int LIVES       = 3,
    parameter int LIVES_W     = 2,
    parameter int FRAME_W     = 16
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                game_tick,
    input  logic [NUM_BTNS-1:0] btn,
    input  logic                collision,
    input  logic                draw_done,
    output logic                draw_req,
    output logic [2:0]          draw_mode,
    output logic                update_en,
    output logic [NUM_BTNS-1:0] btn_pulse,
    output logic [LIVES_W-1:0]  lives,
    output logic [FRAME_W-1:0]  frame_count,
    output logic [3:0]          state,
    output logic                game_over
);

    localparam int TICK_W = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(FRAME_TICKS - 1);

    typedef enum logic [3:0] {
        S_DRAW_START     = 4'd0,
        S_WAIT_START     = 4'd1,
        S_CLEAR          = 4'd2,
        S_DRAW_FRAME     = 4'd3,
        S_STALL          = 4'd4,
        S_ERASE_FRAME    = 4'd5,
        S_UPDATE         = 4'd6,
        S_DRAW_GAME_OVER = 4'd7,
        S_WAIT_GAME_OVER = 4'd8
    } state_t;

    state_t              cur_state, next_state;
    logic                next_draw_req;
    logic                tick_pending, next_tick_pending;
    logic [TICK_W-1:0]   tick_cnt, next_tick_cnt;
    logic [LIVES_W-1:0]  next_lives;
    logic [FRAME_W-1:0]  next_frame_count;
    logic [NUM_BTNS-1:0] btn_meta, btn_sync, btn_prev;

    logic done_ack;
    logic tick_avail;
    logic start_pulse;

    assign done_ack    = draw_req & draw_done;
    assign tick_avail  = tick_pending | game_tick;
    assign start_pulse = btn_pulse[START_BTN];
    assign state       = cur_state;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cur_state    <= S_DRAW_START;
            draw_req     <= 1'b0;
            tick_pending <= 1'b0;
            tick_cnt     <= '0;
            lives        <= LIVES_W'(LIVES);
            frame_count  <= '0;
            btn_meta     <= '0;
            btn_sync     <= '0;
            btn_prev     <= '0;
            btn_pulse    <= '0;
        end else begin
            cur_state    <= next_state;
            draw_req     <= next_draw_req;
            tick_pending <= next_tick_pending;
            tick_cnt     <= next_tick_cnt;
            lives        <= next_lives;
            frame_count  <= next_frame_count;
            btn_meta     <= btn;
            btn_sync     <= btn_meta;
            btn_prev     <= btn_sync;
            btn_pulse    <= btn_sync & ~btn_prev;
        end
    end

    // draw_req is derived from the current state, so it only rises one cycle after a draw state is entered.
    always_comb begin
        next_state        = cur_state;
        next_draw_req     = 1'b0;
        next_tick_pending = 1'b0;
        next_tick_cnt     = tick_cnt;
        next_lives        = lives;
        next_frame_count  = frame_count;
        draw_mode         = 3'd0;
        update_en         = 1'b0;
        game_over         = 1'b0;

        case (cur_state)
            S_DRAW_START: begin
                draw_mode     = 3'd0;
                next_draw_req = ~done_ack;
                if (done_ack) next_state = S_WAIT_START;
            end
            S_WAIT_START: begin
                if (start_pulse) next_state = S_CLEAR;
            end
            S_CLEAR: begin
                draw_mode     = 3'd4;
                next_draw_req = ~done_ack;
                if (done_ack) begin
                    next_state       = S_DRAW_FRAME;
                    next_lives       = LIVES_W'(LIVES);
                    next_frame_count = '0;
                end
            end
            S_DRAW_FRAME: begin
                draw_mode         = 3'd1;
                next_draw_req     = ~done_ack;
                next_tick_pending = tick_pending | game_tick;
                if (done_ack) next_state = S_STALL;
            end
            S_STALL: begin
                // A pending tick is used first; a live tick arriving alongside it becomes the new pending one.
                next_tick_pending = tick_pending & game_tick;
                if (tick_avail) begin
                    if (tick_cnt == TICK_LAST) begin
                        next_tick_cnt = '0;
                        next_state    = S_ERASE_FRAME;
                    end else begin
                        next_tick_cnt = tick_cnt + TICK_W'(1);
                    end
                end
            end
            S_ERASE_FRAME: begin
                draw_mode         = 3'd2;
                next_draw_req     = ~done_ack;
                next_tick_pending = tick_pending | game_tick;
                if (done_ack) next_state = S_UPDATE;
            end
            S_UPDATE: begin
                update_en         = 1'b1;
                next_tick_pending = tick_pending | game_tick;
                if (frame_count != '1) next_frame_count = frame_count + FRAME_W'(1);
                next_state = S_DRAW_FRAME;
                if (collision && lives == LIVES_W'(1)) begin
                    next_lives = '0;
                    next_state = S_DRAW_GAME_OVER;
                end else if (collision && lives > LIVES_W'(1)) begin
                    next_lives = lives - LIVES_W'(1);
                end
            end
            S_DRAW_GAME_OVER: begin
                draw_mode     = 3'd3;
                game_over     = 1'b1;
                next_draw_req = ~done_ack;
                if (done_ack) next_state = S_WAIT_GAME_OVER;
            end
            S_WAIT_GAME_OVER: begin
                game_over = 1'b1;
                if (start_pulse) next_state = S_CLEAR;
            end
            default: begin
                next_state = S_DRAW_START;
            end
        endcase
    end

endmodule
